// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use interlock, taken-branch redirect, I/D-cache stalls.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles / flush_count performance counters.
module hazard_control_unit #(
   parameter int CNT_WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ID_EX_MemRead,
   input  logic [4:0] ID_EX_RegisterRd,
   input  logic [4:0] IF_ID_RegisterRs1,
   input  logic [4:0] IF_ID_RegisterRs2,
   input  logic       IF_ID_UsesRs1,
   input  logic       IF_ID_UsesRs2,
   input  logic       EX_BranchTaken,
   input  logic       ICache_stall,
   input  logic       DCache_stall,
   output logic       PC_Write,
   output logic       IF_ID_Write,
   output logic       ID_EX_Write,
   output logic       EX_MEM_Write,
   output logic       MEM_WB_Write,
   output logic       IF_ID_Flush,
   output logic       ID_EX_Bubble,
   output logic [1:0] ctrl_state
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [15:0]          flush_count
`endif
);

   typedef enum logic [1:0] {
      RUN           = 2'd0,
      FETCH_WAIT    = 2'd1,
      REDIRECT_PEND = 2'd2,
      UNUSED_ST     = 2'd3
   } ctrlState_t;

   ctrlState_t state;
   ctrlState_t nextState;
   logic       loadUse;

   if (CNT_WIDTH < 1) begin : gBadCntWidth
      $error("hazard_control_unit: CNT_WIDTH must be at least 1");
   end

   assign loadUse = ID_EX_MemRead && (ID_EX_RegisterRd != 5'd0) &&
                    (((ID_EX_RegisterRd == IF_ID_RegisterRs1) && IF_ID_UsesRs1) ||
                     ((ID_EX_RegisterRd == IF_ID_RegisterRs2) && IF_ID_UsesRs2));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= RUN;
      end else begin
         state <= nextState;
      end
   end

   // NOTE: every output gets a default before any branch so no path can infer a latch.
   always_comb begin
      nextState    = state;
      PC_Write     = 1'b1;
      IF_ID_Write  = 1'b1;
      ID_EX_Write  = 1'b1;
      EX_MEM_Write = 1'b1;
      MEM_WB_Write = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Bubble = 1'b0;

      if (!rst_n) begin
         nextState    = RUN;
         PC_Write     = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Write  = 1'b0;
         EX_MEM_Write = 1'b0;
         MEM_WB_Write = 1'b0;
         IF_ID_Flush  = 1'b1;
         ID_EX_Bubble = 1'b1;
      end else if (DCache_stall) begin
         // A data-side miss freezes the whole pipe in place, whatever else is pending.
         PC_Write     = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Write  = 1'b0;
         EX_MEM_Write = 1'b0;
         MEM_WB_Write = 1'b0;
      end else begin
         unique case (state)
            RUN, FETCH_WAIT: begin
               // FETCH_WAIT differs from RUN only in which state reports the ongoing miss.
               if (EX_BranchTaken) begin
                  IF_ID_Flush  = 1'b1;
                  ID_EX_Bubble = 1'b1;
                  nextState    = ICache_stall ? REDIRECT_PEND : RUN;
               end else if (ICache_stall) begin
                  PC_Write     = 1'b0;
                  IF_ID_Write  = 1'b0;
                  ID_EX_Bubble = 1'b1;
                  nextState    = FETCH_WAIT;
               end else begin
                  nextState = RUN;
                  if (loadUse) begin
                     PC_Write     = 1'b0;
                     IF_ID_Write  = 1'b0;
                     ID_EX_Bubble = 1'b1;
                  end
               end
            end
            REDIRECT_PEND: begin
               PC_Write     = 1'b0;
               ID_EX_Bubble = 1'b1;
               if (ICache_stall) begin
                  IF_ID_Write = 1'b0;
               end else begin
                  // The fetch that just returned is from the wrong path; drop it.
                  IF_ID_Flush = 1'b1;
                  nextState   = RUN;
               end
            end
            default: begin
               nextState = RUN;
            end
         endcase
      end
   end

   assign ctrl_state = state;

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (!PC_Write && (stall_cycles != {CNT_WIDTH{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_WIDTH'(1);
         end
         if (IF_ID_Flush && (flush_count != 16'hFFFF)) begin
            flush_count <= flush_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed vector table, multi-cycle
// sequences, then randomized traffic against a rule-level reference model.
module tb_hazard_control_unit;

   localparam int CW = 32;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ID_EX_MemRead;
   logic [4:0] ID_EX_RegisterRd;
   logic [4:0] IF_ID_RegisterRs1;
   logic [4:0] IF_ID_RegisterRs2;
   logic       IF_ID_UsesRs1;
   logic       IF_ID_UsesRs2;
   logic       EX_BranchTaken;
   logic       ICache_stall;
   logic       DCache_stall;
   logic       PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write;
   logic       IF_ID_Flush, ID_EX_Bubble;
   logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
   logic [CW-1:0] stall_cycles;
   logic [15:0]   flush_count;
`endif

   logic [6:0] outVec;
   assign outVec = {PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write, MEM_WB_Write,
                    IF_ID_Flush, ID_EX_Bubble};

   always #5 clk = ~clk;

   hazard_control_unit #(.CNT_WIDTH(CW)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .ID_EX_MemRead     (ID_EX_MemRead),
      .ID_EX_RegisterRd  (ID_EX_RegisterRd),
      .IF_ID_RegisterRs1 (IF_ID_RegisterRs1),
      .IF_ID_RegisterRs2 (IF_ID_RegisterRs2),
      .IF_ID_UsesRs1     (IF_ID_UsesRs1),
      .IF_ID_UsesRs2     (IF_ID_UsesRs2),
      .EX_BranchTaken    (EX_BranchTaken),
      .ICache_stall      (ICache_stall),
      .DCache_stall      (DCache_stall),
      .PC_Write          (PC_Write),
      .IF_ID_Write       (IF_ID_Write),
      .ID_EX_Write       (ID_EX_Write),
      .EX_MEM_Write      (EX_MEM_Write),
      .MEM_WB_Write      (MEM_WB_Write),
      .IF_ID_Flush       (IF_ID_Flush),
      .ID_EX_Bubble      (ID_EX_Bubble),
      .ctrl_state        (ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .stall_cycles      (stall_cycles),
      .flush_count       (flush_count)
`endif
   );

   // Output vector bit order: {PC, IF_ID, ID_EX, EX_MEM, MEM_WB write enables, Flush, Bubble}.
   localparam logic [6:0] O_RST   = 7'b0000011;
   localparam logic [6:0] O_IDLE  = 7'b1111100;
   localparam logic [6:0] O_HOLD  = 7'b0011101;
   localparam logic [6:0] O_BR    = 7'b1111111;
   localparam logic [6:0] O_FREEZ = 7'b0000000;
   localparam logic [6:0] O_REDIR = 7'b0111111;

   typedef struct {
      logic       r, mr;
      logic [4:0] rd, rs1, rs2;
      logic       u1, u2, br, ic, dc;
      logic [6:0] eo;
      logic [1:0] es;
   } vec_t;

   vec_t vecs[$];
   int   nTests = 0;
   int   nFail  = 0;
   logic [CW-1:0] mdlStall;
   logic [15:0]   mdlFlush;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic r, mr, input logic [4:0] rd, rs1, rs2,
                        input logic u1, u2, br, ic, dc);
      rst_n             = r;
      ID_EX_MemRead     = mr;
      ID_EX_RegisterRd  = rd;
      IF_ID_RegisterRs1 = rs1;
      IF_ID_RegisterRs2 = rs2;
      IF_ID_UsesRs1     = u1;
      IF_ID_UsesRs2     = u2;
      EX_BranchTaken    = br;
      ICache_stall      = ic;
      DCache_stall      = dc;
   endtask

   // Samples mid-cycle, then advances the counter model with this cycle's expected outputs.
   task automatic cycleCheck(input string tag, input logic [6:0] eo, input logic [1:0] es);
      @(negedge clk);
      check({tag, " outputs"}, 64'(outVec), 64'(eo));
      check({tag, " ctrl_state"}, 64'(ctrl_state), 64'(es));
`ifdef HAZARD_PERF_CNT_EN
      check({tag, " stall_cycles"}, 64'(stall_cycles), 64'(mdlStall));
      check({tag, " flush_count"}, 64'(flush_count), 64'(mdlFlush));
`endif
      if (!rst_n) begin
         mdlStall = '0;
         mdlFlush = '0;
      end else begin
         if (!eo[6] && mdlStall != '1) mdlStall = mdlStall + 1'b1;
         if (eo[1] && mdlFlush != '1) mdlFlush = mdlFlush + 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic addVec(input logic r, mr, input logic [4:0] rd, rs1, rs2,
                         input logic u1, u2, br, ic, dc, input logic [6:0] eo, input logic [1:0] es);
      vec_t v;
      v.r = r; v.mr = mr; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
      v.u1 = u1; v.u2 = u2; v.br = br; v.ic = ic; v.dc = dc; v.eo = eo; v.es = es;
      vecs.push_back(v);
   endtask

   // Reference: a prioritized rule list. Modes: 0 normal, 1 waiting on fetch, 2 redirect pending.
   function automatic void refModel(input int mode, input logic r, mr, input logic [4:0] rd, rs1, rs2,
                                    input logic u1, u2, br, ic, dc,
                                    output logic [6:0] o, output int nextMode);
      bit hazard = mr && (rd != 0) && ((rd == rs1 && u1) || (rd == rs2 && u2));
      if (!r) begin
         o = O_RST;   nextMode = 0;
      end else if (dc) begin
         o = O_FREEZ; nextMode = mode;
      end else if (mode == 2) begin
         o = ic ? O_HOLD : O_REDIR;
         nextMode = ic ? 2 : 0;
      end else if (br) begin
         o = O_BR;    nextMode = ic ? 2 : 0;
      end else if (ic) begin
         o = O_HOLD;  nextMode = 1;
      end else begin
         o = hazard ? O_HOLD : O_IDLE;
         nextMode = 0;
      end
   endfunction

   initial begin
      int mode;
      int nextMode;
      logic [6:0] eo;
      logic r, mr, u1, u2, br, ic, dc;
      logic [4:0] rd, rs1, rs2;

      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      mdlStall = '0;
      mdlFlush = '0;

      //     r  mr rd rs1 rs2 u1 u2 br ic dc  expected  state
      addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,   2'd0);
      addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE,  2'd0);
      addVec(1, 1, 5, 5, 0, 1, 0, 0, 0, 0, O_HOLD,  2'd0);
      addVec(1, 1, 7, 3, 7, 0, 1, 0, 0, 0, O_HOLD,  2'd0);
      addVec(1, 1, 0, 0, 0, 1, 0, 0, 0, 0, O_IDLE,  2'd0);
      addVec(1, 1, 5, 5, 0, 0, 0, 0, 0, 0, O_IDLE,  2'd0);
      addVec(1, 0, 5, 5, 0, 1, 0, 0, 0, 0, O_IDLE,  2'd0);
      addVec(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, O_BR,    2'd0);
      addVec(1, 1, 5, 5, 0, 1, 0, 1, 0, 0, O_BR,    2'd0);
      addVec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_HOLD,  2'd0);
      addVec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_HOLD,  2'd1);
      addVec(1, 1, 5, 5, 0, 1, 0, 0, 1, 0, O_HOLD,  2'd1);
      addVec(1, 1, 5, 5, 0, 1, 0, 0, 0, 0, O_HOLD,  2'd1);
      addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE,  2'd0);
      addVec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_HOLD,  2'd0);
      addVec(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_FREEZ, 2'd1);
      addVec(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_BR,    2'd1);
      addVec(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_HOLD,  2'd2);
      addVec(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, O_FREEZ, 2'd2);
      addVec(1, 1, 5, 5, 0, 1, 0, 0, 0, 0, O_REDIR, 2'd2);
      addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE,  2'd0);
      addVec(1, 1, 5, 5, 0, 1, 0, 1, 0, 1, O_FREEZ, 2'd0);
      addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE,  2'd0);
      addVec(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_BR,    2'd0);
      addVec(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_HOLD,  2'd2);
      addVec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_RST,   2'd2);
      addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE,  2'd0);

      foreach (vecs[i]) begin
         drive(vecs[i].r, vecs[i].mr, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
               vecs[i].u1, vecs[i].u2, vecs[i].br, vecs[i].ic, vecs[i].dc);
         cycleCheck($sformatf("vec%0d", i), vecs[i].eo, vecs[i].es);
      end

      // I-cache miss lasting three cycles, then release.
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
         cycleCheck($sformatf("icmiss%0d", i), O_HOLD, (i == 0) ? 2'd0 : 2'd1);
      end
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycleCheck("icmiss_release", O_IDLE, 2'd1);
      cycleCheck("icmiss_after", O_IDLE, 2'd0);

      // Taken branch while fetch misses for four cycles.
      drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      cycleCheck("redir_branch", O_BR, 2'd0);
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
         cycleCheck($sformatf("redir_wait%0d", i), O_HOLD, 2'd2);
      end
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycleCheck("redir_release", O_REDIR, 2'd2);
      cycleCheck("redir_after", O_IDLE, 2'd0);

      mode = 0;
      for (int n = 0; n < 3000; n++) begin
         r   = ($urandom_range(0, 99) != 0);
         mr  = 1'($urandom_range(0, 1));
         rd  = 5'($urandom_range(0, 3));
         rs1 = 5'($urandom_range(0, 3));
         rs2 = 5'($urandom_range(0, 3));
         u1  = 1'($urandom_range(0, 1));
         u2  = 1'($urandom_range(0, 1));
         br  = ($urandom_range(0, 99) < 20);
         ic  = ($urandom_range(0, 99) < 35);
         dc  = ($urandom_range(0, 99) < 15);
         refModel(mode, r, mr, rd, rs1, rs2, u1, u2, br, ic, dc, eo, nextMode);
         drive(r, mr, rd, rs1, rs2, u1, u2, br, ic, dc);
         cycleCheck($sformatf("rand%0d", n), eo, 2'(mode));
         mode = nextMode;
      end

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
